// File: rtl/alg3_bits_to_bytes_stream_ctrl_if.sv
// Bit-beat input and byte output handshake bundle for the
// BitsToBytes stream controller.
interface alg3_bits_to_bytes_stream_ctrl_if #(
    parameter int IN_W = 1
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_bits;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_byte;
    logic            out_last;

    modport master (
        output in_valid,
        output in_bits,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_byte,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_bits,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_byte,
        output out_last
    );
endinterface

// File: rtl/alg3_bits_to_bytes_stream_ctrl.sv
// ML-KEM BitsToBytes stream packer: IN_W-bit beats in,
// LSB-first packed bytes out, framed by a byte count.
module alg3_bits_to_bytes_stream_ctrl #(
    parameter int IN_W  = 1,
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             done,
    alg3_bits_to_bytes_stream_ctrl_if.slave s
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_last_q, out_last_d;

    logic [7:0] acc_ins;
    logic       in_fire;
    logic       out_fire;
    logic       byte_fire;
    logic       last_byte;

    assign s.in_ready  = (state_q == PACK) &&
                         (!out_valid_q || s.out_ready);
    assign s.out_valid = out_valid_q;
    assign s.out_byte  = out_byte_q;
    assign s.out_last  = out_last_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    assign in_fire   = s.in_valid && s.in_ready;
    assign out_fire  = out_valid_q && s.out_ready;
    assign byte_fire = in_fire && (bitcnt_q == 3'(8 - IN_W));
    assign last_byte = (remaining_q == LEN_W'(1));

    // Next-state, accumulator and output-register logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        bitcnt_d    = bitcnt_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        acc_ins     = acc_q;
        acc_ins[bitcnt_q +: IN_W] = s.in_bits;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len != '0) begin
                        remaining_d = frame_len;
                        bitcnt_d    = '0;
                        acc_d       = '0;
                        state_d     = PACK;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            PACK: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (in_fire) begin
                    acc_d    = acc_ins;
                    bitcnt_d = bitcnt_q + 3'(IN_W);
                end
                // A completing beat reloads the output even
                // while the previous byte is handshaking.
                if (byte_fire) begin
                    acc_d       = '0;
                    bitcnt_d    = '0;
                    out_byte_d  = acc_ins;
                    out_valid_d = 1'b1;
                    out_last_d  = last_byte;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (last_byte) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            bitcnt_q    <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bitcnt_q    <= bitcnt_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_alg3_bits_to_bytes_stream_ctrl.sv
// Directed bench for the BitsToBytes stream packer at
// IN_W = 1, 8 and 4.
module tb_alg3_bits_to_bytes_stream_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        st1, st8, st4;
    logic [10:0] fl1, fl8, fl4;
    logic        busy1, busy8, busy4;
    logic        done1, done8, done4;

    alg3_bits_to_bytes_stream_ctrl_if #(.IN_W(1)) i1 ();
    alg3_bits_to_bytes_stream_ctrl_if #(.IN_W(8)) i8 ();
    alg3_bits_to_bytes_stream_ctrl_if #(.IN_W(4)) i4 ();

    alg3_bits_to_bytes_stream_ctrl #(.IN_W(1), .LEN_W(11)) u1 (
        .clk(clk), .rst(rst), .start(st1), .frame_len(fl1),
        .busy(busy1), .done(done1), .s(i1.slave));
    alg3_bits_to_bytes_stream_ctrl #(.IN_W(8), .LEN_W(11)) u8 (
        .clk(clk), .rst(rst), .start(st8), .frame_len(fl8),
        .busy(busy8), .done(done8), .s(i8.slave));
    alg3_bits_to_bytes_stream_ctrl #(.IN_W(4), .LEN_W(11)) u4 (
        .clk(clk), .rst(rst), .start(st4), .frame_len(fl4),
        .busy(busy4), .done(done4), .s(i4.slave));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] bits1;
    logic [7:0]  beats8 [4];
    logic [7:0]  a5;

    initial begin
        st1 = 0; st8 = 0; st4 = 0;
        fl1 = '0; fl8 = '0; fl4 = '0;
        i1.in_valid = 0; i1.in_bits = '0; i1.out_ready = 1;
        i8.in_valid = 0; i8.in_bits = '0; i8.out_ready = 1;
        i4.in_valid = 0; i4.in_bits = '0; i4.out_ready = 0;
        bits1 = 16'h0102;
        beats8[0] = 8'hAA; beats8[1] = 8'h55;
        beats8[2] = 8'h0F; beats8[3] = 8'hF0;
        a5 = 8'hA5;

        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_in_ready", i1.in_ready, 0);
        chk("rst_out_valid", i1.out_valid, 0);
        chk("rst_out_byte", i1.out_byte, 0);
        chk("rst_out_last", i1.out_last, 0);
        tick();
        tick();
        rst = 0;
        tick();

        // IN_W=1, two bytes 0x02 then 0x01
        st1 = 1; fl1 = 11'd2;
        tick();
        st1 = 0;
        chk("t1_busy", busy1, 1);
        for (int i = 0; i < 16; i++) begin
            i1.in_valid = 1; i1.in_bits = bits1[i];
            #1;
            chk("t1_in_ready", i1.in_ready, 1);
            tick();
            if (i == 7) begin
                chk("t1_b0_valid", i1.out_valid, 1);
                chk("t1_b0_byte", i1.out_byte, 8'h02);
                chk("t1_b0_last", i1.out_last, 0);
            end
            if (i == 8) chk("t1_b0_drop", i1.out_valid, 0);
        end
        i1.in_valid = 0;
        chk("t1_b1_valid", i1.out_valid, 1);
        chk("t1_b1_byte", i1.out_byte, 8'h01);
        chk("t1_b1_last", i1.out_last, 1);
        chk("t1_drain_rdy", i1.in_ready, 0);
        tick();
        chk("t1_done", done1, 1);
        chk("t1_ov_clr", i1.out_valid, 0);
        chk("t1_last_clr", i1.out_last, 0);
        tick();
        chk("t1_done_off", done1, 0);
        chk("t1_idle", busy1, 0);

        // IN_W=8, back-to-back bytes
        st8 = 1; fl8 = 11'd4;
        tick();
        st8 = 0;
        for (int i = 0; i < 4; i++) begin
            i8.in_valid = 1; i8.in_bits = beats8[i];
            #1;
            chk("t2_in_ready", i8.in_ready, 1);
            tick();
            chk("t2_valid", i8.out_valid, 1);
            chk("t2_byte", i8.out_byte, {24'd0, beats8[i]});
            chk("t2_last", i8.out_last, (i == 3) ? 1 : 0);
        end
        i8.in_valid = 0;
        tick();
        chk("t2_done", done8, 1);
        chk("t2_ov_clr", i8.out_valid, 0);
        tick();
        chk("t2_idle", busy8, 0);

        // IN_W=4, one byte held under backpressure
        st4 = 1; fl4 = 11'd1;
        tick();
        st4 = 0;
        i4.in_valid = 1; i4.in_bits = 4'h3;
        tick();
        i4.in_bits = 4'hC;
        tick();
        i4.in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", i4.out_valid, 1);
            chk("t3_hold_byte", i4.out_byte, 8'hC3);
            chk("t3_hold_last", i4.out_last, 1);
            chk("t3_hold_rdy", i4.in_ready, 0);
            chk("t3_hold_done", done4, 0);
            tick();
        end
        i4.out_ready = 1;
        tick();
        chk("t3_done", done4, 1);
        chk("t3_ov_clr", i4.out_valid, 0);
        tick();
        chk("t3_idle", busy4, 0);

        // zero-length frame
        st1 = 1; fl1 = 11'd0;
        tick();
        st1 = 0;
        chk("t4_busy", busy1, 1);
        chk("t4_done", done1, 1);
        chk("t4_no_out", i1.out_valid, 0);
        tick();
        chk("t4_idle", busy1, 0);
        chk("t4_done_off", done1, 0);

        // reset after 11 of 16 bits, then a clean frame
        st1 = 1; fl1 = 11'd2;
        tick();
        st1 = 0;
        for (int i = 0; i < 11; i++) begin
            i1.in_valid = 1; i1.in_bits = 1'b1;
            tick();
            if (i == 7) chk("t5_ff", i1.out_byte, 8'hFF);
        end
        i1.in_valid = 0;
        rst = 1;
        #1;
        chk("t5_rst_busy", busy1, 0);
        chk("t5_rst_byte", i1.out_byte, 0);
        chk("t5_rst_valid", i1.out_valid, 0);
        chk("t5_rst_last", i1.out_last, 0);
        chk("t5_rst_rdy", i1.in_ready, 0);
        chk("t5_rst_done", done1, 0);
        tick();
        rst = 0;
        st1 = 1; fl1 = 11'd1;
        tick();
        st1 = 0;
        for (int i = 0; i < 8; i++) begin
            i1.in_valid = 1; i1.in_bits = a5[i];
            tick();
        end
        i1.in_valid = 0;
        chk("t5_valid", i1.out_valid, 1);
        chk("t5_byte", i1.out_byte, 8'hA5);
        chk("t5_last", i1.out_last, 1);
        tick();
        chk("t5_done", done1, 1);
        tick();

        // start during PACK is ignored
        st8 = 1; fl8 = 11'd2;
        tick();
        st8 = 0;
        i8.in_valid = 1; i8.in_bits = 8'h11;
        tick();
        chk("t6_b0", i8.out_byte, 8'h11);
        chk("t6_b0_last", i8.out_last, 0);
        st8 = 1; fl8 = 11'd5;
        i8.in_bits = 8'h22;
        tick();
        st8 = 0;
        i8.in_valid = 0;
        chk("t6_b1", i8.out_byte, 8'h22);
        chk("t6_b1_last", i8.out_last, 1);
        chk("t6_drain_rdy", i8.in_ready, 0);
        tick();
        chk("t6_done", done8, 1);
        tick();
        chk("t6_idle", busy8, 0);
        tick();
        chk("t6_still_idle", busy8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
